// File: rtl/kgp_imm_pkg.sv
// Shared encodings for the KGP-RISC immediate-generation stage.
package kgp_imm_pkg;

    typedef enum logic [1:0] {
        IMM_SIGN  = 2'b00,
        IMM_ZERO  = 2'b01,
        IMM_SHAMT = 2'b10,
        IMM_UPPER = 2'b11
    } imm_mode_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } buf_state_e;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender: sign, zero, shift-amount or upper placement.
module imm_ext_core
    import kgp_imm_pkg::*;
#(
    parameter int IN_W    = 16,
    parameter int OUT_W   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic [1:0]       mode,
    input  logic [IN_W-1:0]  imm,
    output logic [OUT_W-1:0] ext
);

    always_comb begin
        ext = '0;
        case (mode)
            IMM_SIGN:  ext = OUT_W'($signed(imm));
            IMM_ZERO:  ext = OUT_W'(imm);
            IMM_SHAMT: ext = OUT_W'(imm[IN_W-1 -: SHAMT_W]);
            // Shift form avoids a zero-width replication when OUT_W == IN_W.
            IMM_UPPER: ext = OUT_W'(imm) << (OUT_W - IN_W);
            default:   ext = '0;
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender with a 2-entry skid buffer, flush and sideband tag.
// Optional transfer statistics are enabled by defining IMM_STATS_EN.
module imm_extend_pipe
    import kgp_imm_pkg::*;
#(
    parameter int IN_W    = 16,
    parameter int OUT_W   = 32,
    parameter int SHAMT_W = 5,
    parameter int TAG_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_mode,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic [1:0]       dbg_state
`ifdef IMM_STATS_EN
    ,
    output logic [31:0]      stat_count,
    output logic             stat_sat
`endif
);

    generate
        if (OUT_W < IN_W) begin : g_bad_width
            $error("imm_extend_pipe: OUT_W must be >= IN_W");
        end
        if (SHAMT_W > IN_W) begin : g_bad_shamt
            $error("imm_extend_pipe: SHAMT_W must be <= IN_W");
        end
    endgenerate

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; in_ready is registered and never looks at in_valid.
    buf_state_e       state_q, state_d;
    logic             in_ready_q, out_valid_q;
    logic [OUT_W-1:0] main_data_q, skid_data_q, ext_data;
    logic [TAG_W-1:0] main_tag_q, skid_tag_q;
    logic             in_fire, out_fire;
    logic             ld_main_in, ld_main_skid, ld_skid;

    imm_ext_core #(
        .IN_W    (IN_W),
        .OUT_W   (OUT_W),
        .SHAMT_W (SHAMT_W)
    ) u_core (
        .mode (in_mode),
        .imm  (in_imm),
        .ext  (ext_data)
    );

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid_q & out_ready;

    always_comb begin
        state_d      = state_q;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d    = ST_ONE;
                        ld_main_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        ld_main_in = 1'b1;
                    end else if (in_fire) begin
                        state_d = ST_FULL;
                        ld_skid = 1'b1;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        state_d      = ST_ONE;
                        ld_main_skid = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            main_data_q <= '0;
            main_tag_q  <= '0;
            skid_data_q <= '0;
            skid_tag_q  <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= (state_d != ST_EMPTY);
            in_ready_q  <= (state_d != ST_FULL);
            if (ld_main_in) begin
                main_data_q <= ext_data;
                main_tag_q  <= in_tag;
            end else if (ld_main_skid) begin
                main_data_q <= skid_data_q;
                main_tag_q  <= skid_tag_q;
            end
            if (ld_skid) begin
                skid_data_q <= ext_data;
                skid_tag_q  <= in_tag;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_data_q;
    assign out_tag   = main_tag_q;
    assign dbg_state = state_q;

`ifdef IMM_STATS_EN
    logic [31:0] stat_cnt_q;
    logic        stat_sat_q;

    // Counts accepted inputs even when a flush discards them; survives flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_cnt_q <= '0;
            stat_sat_q <= 1'b0;
        end else if (in_fire && (stat_cnt_q != 32'hFFFF_FFFF)) begin
            stat_cnt_q <= stat_cnt_q + 32'd1;
            if (stat_cnt_q == 32'hFFFF_FFFE) begin
                stat_sat_q <= 1'b1;
            end
        end
    end

    assign stat_count = stat_cnt_q;
    assign stat_sat   = stat_sat_q;
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: FIFO-occupancy reference model plus directed checks.
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_mode = 2'b00;
    logic [15:0] in_imm = '0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [4:0]  out_tag;
    logic [1:0]  dbg_state;
`ifdef IMM_STATS_EN
    logic [31:0] stat_count;
    logic        stat_sat;
`endif

    int n_vec = 0;
    int n_bad = 0;
    logic [36:0] exp_q[$];

    imm_extend_pipe #(.IN_W(16), .OUT_W(32), .SHAMT_W(5), .TAG_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_imm(in_imm), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag), .dbg_state(dbg_state)
`ifdef IMM_STATS_EN
        , .stat_count(stat_count), .stat_sat(stat_sat)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_ext(input logic [1:0] m, input logic [15:0] imm);
        int unsigned v;
        v = 32'(imm);
        case (m)
            2'd0:    return (v >= 32768) ? v + 32'hFFFF_0000 : v;
            2'd1:    return v;
            2'd2:    return v / 2048;
            default: return v * 65536;
        endcase
    endfunction

    // Called at a falling edge: checks outputs against the model, drives the
    // inputs for the next rising edge, then advances the model past that edge.
    task automatic step(input logic v, input logic [1:0] m, input logic [15:0] imm,
                        input logic [4:0] t, input logic ordy, input logic fl);
        logic exp_v, exp_r, in_f, out_f;
        exp_v = (exp_q.size() > 0);
        exp_r = (exp_q.size() < 2);
        n_vec++;
        if (out_valid !== exp_v) begin
            n_bad++;
            $display("FAIL out_valid: got %b want %b at %0t", out_valid, exp_v, $time);
        end
        n_vec++;
        if (in_ready !== exp_r) begin
            n_bad++;
            $display("FAIL in_ready: got %b want %b at %0t", in_ready, exp_r, $time);
        end
        if (exp_v) begin
            n_vec++;
            if ({out_tag, out_data} !== exp_q[0]) begin
                n_bad++;
                $display("FAIL out_payload: got tag=%0d data=%h want tag=%0d data=%h at %0t",
                         out_tag, out_data, exp_q[0][36:32], exp_q[0][31:0], $time);
            end
        end
        in_valid  = v;
        in_mode   = m;
        in_imm    = imm;
        in_tag    = t;
        out_ready = ordy;
        flush     = fl;
        in_f  = v && exp_r;
        out_f = exp_v && ordy;
        if (fl) begin
            exp_q.delete();
        end else begin
            if (out_f) void'(exp_q.pop_front());
            if (in_f) exp_q.push_back({t, ref_ext(m, imm)});
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 2'b00, 16'h0, 5'd0, ordy, 1'b0);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0 || out_tag !== 5'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got v=%b r=%b d=%h t=%0d want v=0 r=1 d=0 t=0",
                     out_valid, in_ready, out_data, out_tag);
        end
        rst = 1'b1;
        @(negedge clk);
        exp_q.delete();
    endtask

    task automatic test_first_sign;
        step(1'b1, 2'b00, 16'h8001, 5'd3, 1'b1, 1'b0);
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 32'hFFFF_8001 || out_tag !== 5'd3) begin
            n_bad++;
            $display("FAIL first_sign: got v=%b d=%h t=%0d want v=1 d=ffff8001 t=3",
                     out_valid, out_data, out_tag);
        end
        idle(1'b1);
    endtask

    task automatic test_mode_sweep;
        logic [31:0] want[3];
        want[0] = 32'h0000_A5C3;
        want[1] = 32'h0000_0014;
        want[2] = 32'hA5C3_0000;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 2'(i + 1), 16'hA5C3, 5'(i + 10), 1'b1, 1'b0);
            n_vec++;
            if (out_data !== want[i]) begin
                n_bad++;
                $display("FAIL mode_sweep[%0d]: got %h want %h", i + 1, out_data, want[i]);
            end
        end
        idle(1'b1);
    endtask

    task automatic test_back_pressure;
        step(1'b1, 2'b00, 16'h1111, 5'd1, 1'b0, 1'b0);
        step(1'b1, 2'b01, 16'h2222, 5'd2, 1'b0, 1'b0);
        n_vec++;
        if (dbg_state !== kgp_imm_pkg::ST_FULL || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_full: got state=%0d ready=%b want state=2 ready=0", dbg_state, in_ready);
        end
        step(1'b1, 2'b11, 16'h3333, 5'd3, 1'b0, 1'b0);
        step(1'b1, 2'b11, 16'h3333, 5'd3, 1'b1, 1'b0);
        step(1'b1, 2'b11, 16'h3333, 5'd3, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) idle(1'b1);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL bp_drain: got %0d left want 0", exp_q.size());
        end
    endtask

    task automatic test_flush;
        step(1'b1, 2'b00, 16'hDEAD, 5'd7, 1'b0, 1'b0);
        step(1'b1, 2'b01, 16'hBEEF, 5'd8, 1'b0, 1'b0);
        step(1'b1, 2'b10, 16'hCAFE, 5'd9, 1'b0, 1'b1);
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL flush: got v=%b r=%b want v=0 r=1", out_valid, in_ready);
        end
        step(1'b1, 2'b01, 16'h0042, 5'd11, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);
    endtask

    task automatic test_async_reset;
        step(1'b1, 2'b01, 16'h7777, 5'd5, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0 || out_tag !== 5'h0) begin
            n_bad++;
            $display("FAIL async_reset: got v=%b r=%b d=%h t=%0d want v=0 r=1 d=0 t=0",
                     out_valid, in_ready, out_data, out_tag);
        end
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_tag !== 5'h0) begin
            n_bad++;
            $display("FAIL post_reset: got v=%b d=%h t=%0d want v=0 d=0 t=0", out_valid, out_data, out_tag);
        end
        idle(1'b1);
    endtask

    task automatic test_random;
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom),
                 5'($urandom_range(0, 31)), ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 24) == 0));
        end
        for (int i = 0; i < 3; i++) idle(1'b1);
    endtask

`ifdef IMM_STATS_EN
    task automatic test_stats;
        dut.stat_cnt_q = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) step(1'b1, 2'b00, 16'(i), 5'(i), 1'b1, 1'b0);
        idle(1'b1);
        n_vec++;
        if (stat_count !== 32'hFFFF_FFFF || stat_sat !== 1'b1) begin
            n_bad++;
            $display("FAIL stats: got cnt=%h sat=%b want cnt=ffffffff sat=1", stat_count, stat_sat);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_first_sign();
        test_mode_sweep();
        test_back_pressure();
        test_flush();
        test_async_reset();
        test_random();
`ifdef IMM_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
